// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution: taken decision, target, fetch PC register,
// post-redirect squash window and misaligned-target trap hand-off.
module branch_resolve #(
    parameter int                XLEN        = 32,
    parameter logic [XLEN-1:0]   RESET_PC    = 32'h0000_0000,
    parameter logic [XLEN-1:0]   TRAP_VEC    = 32'h0000_0100,
    parameter int                FLUSH_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            ex_valid_i,
    input  logic            ex_is_branch_i,
    input  logic            ex_is_jal_i,
    input  logic            ex_is_jalr_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_imm_i,
    input  logic [XLEN-1:0] ex_rs1_data_i,
    input  logic            br_less_i,
    input  logic            br_equal_i,
    input  logic            trap_ack_i,
    output logic            br_unsigned_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] link_o,
    output logic            redirect_o,
    output logic            flush_o,
    output logic            illegal_o,
    output logic            trap_o,
    output logic [XLEN-1:0] trap_addr_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } state_t;

    localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_DEPTH);
    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] trap_addr_q, trap_addr_d;

    logic            cond_taken;
    logic            cond_illegal;
    logic            take;
    logic            in_run;
    logic            event_hit;
    logic            misaligned;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] jalr_sum;

    // Decision datapath: purely combinational, same cycle as the EX inputs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cond_taken   = 1'b0;
        cond_illegal = 1'b0;
        unique case (ex_funct3_i)
            3'b000:         cond_taken   = br_equal_i;
            3'b001:         cond_taken   = !br_equal_i;
            3'b100, 3'b110: cond_taken   = br_less_i;
            3'b101, 3'b111: cond_taken   = !br_less_i;
            default:        cond_illegal = 1'b1;
        endcase

        jalr_sum = ex_rs1_data_i + ex_imm_i;
        if (ex_is_jalr_i) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            target = ex_pc_i + ex_imm_i;
        end

        in_run     = (state_q == RUN);
        take       = ex_is_jalr_i || ex_is_jal_i || (ex_is_branch_i && cond_taken);
        event_hit  = ex_valid_i && in_run && take;
        misaligned = event_hit && target[1];
    end

    assign br_unsigned_o = ex_funct3_i[1];
    assign link_o        = ex_pc_i + INSN_BYTES;
    assign redirect_o    = event_hit && !misaligned;
    assign illegal_o     = ex_valid_i && in_run && ex_is_branch_i && cond_illegal;

    // Next-state logic for the PC / squash / trap FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        flush_d     = flush_q;
        trap_d      = 1'b0;
        trap_addr_d = trap_addr_q;

        unique case (state_q)
            RUN: begin
                if (redirect_o) begin
                    // Redirect wins over fetch back-pressure.
                    pc_d    = target;
                    cnt_d   = FLUSH_INIT;
                    flush_d = 1'b1;
                    state_d = FLUSH;
                end else if (misaligned) begin
                    pc_d        = TRAP_VEC;
                    trap_d      = 1'b1;
                    trap_addr_d = target;
                    flush_d     = 1'b1;
                    state_d     = TRAP;
                end else if (!stall_i) begin
                    pc_d = pc_q + INSN_BYTES;
                end
            end
            FLUSH: begin
                if (!stall_i) begin
                    pc_d = pc_q + INSN_BYTES;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        flush_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            TRAP: begin
                if (trap_ack_i) begin
                    flush_d = 1'b0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                flush_d = 1'b0;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign pc_o        = pc_q;
    assign flush_o     = flush_q;
    assign trap_o      = trap_q;
    assign trap_addr_o = trap_addr_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        ex_valid_i;
    logic        ex_is_branch_i;
    logic        ex_is_jal_i;
    logic        ex_is_jalr_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_imm_i;
    logic [31:0] ex_rs1_data_i;
    logic        br_less_i;
    logic        br_equal_i;
    logic        trap_ack_i;
    logic        br_unsigned_o;
    logic [31:0] pc_o;
    logic [31:0] link_o;
    logic        redirect_o;
    logic        flush_o;
    logic        illegal_o;
    logic        trap_o;
    logic [31:0] trap_addr_o;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .ex_valid_i    (ex_valid_i),
        .ex_is_branch_i(ex_is_branch_i),
        .ex_is_jal_i   (ex_is_jal_i),
        .ex_is_jalr_i  (ex_is_jalr_i),
        .ex_funct3_i   (ex_funct3_i),
        .ex_pc_i       (ex_pc_i),
        .ex_imm_i      (ex_imm_i),
        .ex_rs1_data_i (ex_rs1_data_i),
        .br_less_i     (br_less_i),
        .br_equal_i    (br_equal_i),
        .trap_ack_i    (trap_ack_i),
        .br_unsigned_o (br_unsigned_o),
        .pc_o          (pc_o),
        .link_o        (link_o),
        .redirect_o    (redirect_o),
        .flush_o       (flush_o),
        .illegal_o     (illegal_o),
        .trap_o        (trap_o),
        .trap_addr_o   (trap_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        ex_valid_i     = 1'b0;
        ex_is_branch_i = 1'b0;
        ex_is_jal_i    = 1'b0;
        ex_is_jalr_i   = 1'b0;
    endtask

    task automatic drive_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                                input logic lt, input logic eq);
        ex_valid_i     = 1'b1;
        ex_is_branch_i = 1'b1;
        ex_is_jal_i    = 1'b0;
        ex_is_jalr_i   = 1'b0;
        ex_funct3_i    = f3;
        ex_pc_i        = pc;
        ex_imm_i       = imm;
        br_less_i      = lt;
        br_equal_i     = eq;
        #1;
    endtask

    initial begin
        rst_ni        = 1'b0;
        stall_i       = 1'b0;
        trap_ack_i    = 1'b0;
        ex_funct3_i   = 3'b000;
        ex_pc_i       = '0;
        ex_imm_i      = '0;
        ex_rs1_data_i = '0;
        br_less_i     = 1'b0;
        br_equal_i    = 1'b0;
        idle();

        // Reset and free-running fetch
        step();
        step();
        check("rst_pc", pc_o, 32'h0);
        check("rst_flush", {31'b0, flush_o}, 32'h0);
        check("rst_trap", {31'b0, trap_o}, 32'h0);
        check("rst_trap_addr", trap_addr_o, 32'h0);
        rst_ni = 1'b1;
        step(); check("run_pc4", pc_o, 32'h4);
        step(); check("run_pc8", pc_o, 32'h8);
        step(); check("run_pc12", pc_o, 32'hC);
        stall_i = 1'b1;
        step(); check("stall_hold", pc_o, 32'hC);
        stall_i = 1'b0;

        // BEQ taken, then two flush cycles that ignore a valid taken branch
        drive_branch(3'b000, 32'h40, 32'h20, 1'b0, 1'b1);
        check("beq_redirect", {31'b0, redirect_o}, 32'h1);
        check("beq_link", link_o, 32'h44);
        step();
        check("beq_pc", pc_o, 32'h60);
        check("beq_flush1", {31'b0, flush_o}, 32'h1);
        check("flush_no_redirect1", {31'b0, redirect_o}, 32'h0);
        step();
        check("flush_pc", pc_o, 32'h64);
        check("beq_flush2", {31'b0, flush_o}, 32'h1);
        check("flush_no_redirect2", {31'b0, redirect_o}, 32'h0);
        drive_branch(3'b010, 32'h40, 32'h20, 1'b0, 1'b1);
        check("flush_no_illegal", {31'b0, illegal_o}, 32'h0);
        idle();
        step();
        check("flush_done", {31'b0, flush_o}, 32'h0);
        check("flush_done_pc", pc_o, 32'h68);

        // Signed/unsigned select and BGE/BLTU decisions
        ex_funct3_i = 3'b110; #1;
        check("unsigned_bltu", {31'b0, br_unsigned_o}, 32'h1);
        ex_funct3_i = 3'b101; #1;
        check("unsigned_bge", {31'b0, br_unsigned_o}, 32'h0);
        drive_branch(3'b101, 32'h68, 32'h40, 1'b1, 1'b0);
        check("bge_not_taken", {31'b0, redirect_o}, 32'h0);
        step();
        check("bge_pc", pc_o, 32'h6C);
        drive_branch(3'b110, 32'h80, 32'h10, 1'b1, 1'b0);
        check("bltu_taken", {31'b0, redirect_o}, 32'h1);
        step();
        check("bltu_pc", pc_o, 32'h90);
        idle();
        step();
        step();
        check("bltu_flush_end", {31'b0, flush_o}, 32'h0);
        check("bltu_pc_after", pc_o, 32'h98);

        // JALR to misaligned target -> trap
        ex_valid_i    = 1'b1;
        ex_is_jalr_i  = 1'b1;
        ex_rs1_data_i = 32'h1003;
        ex_imm_i      = 32'h0;
        #1;
        check("jalr_mis_no_redirect", {31'b0, redirect_o}, 32'h0);
        step();
        idle();
        check("trap_pulse", {31'b0, trap_o}, 32'h1);
        check("trap_addr", trap_addr_o, 32'h1002);
        check("trap_pc", pc_o, 32'h100);
        check("trap_flush", {31'b0, flush_o}, 32'h1);
        step();
        check("trap_pulse_end", {31'b0, trap_o}, 32'h0);
        check("trap_pc_hold", pc_o, 32'h100);
        check("trap_flush_hold", {31'b0, flush_o}, 32'h1);
        trap_ack_i = 1'b1;
        step();
        trap_ack_i = 1'b0;
        check("ack_pc", pc_o, 32'h100);
        check("ack_flush", {31'b0, flush_o}, 32'h0);
        step();
        check("resume_pc", pc_o, 32'h104);
        trap_ack_i = 1'b1;
        step();
        trap_ack_i = 1'b0;
        check("ack_in_run_ignored", pc_o, 32'h108);

        // JALR aligned with wrap; JAL link wrap
        ex_valid_i    = 1'b1;
        ex_is_jalr_i  = 1'b1;
        ex_rs1_data_i = 32'hFFFF_FFFC;
        ex_imm_i      = 32'h8;
        #1;
        check("jalr_wrap_redirect", {31'b0, redirect_o}, 32'h1);
        step();
        idle();
        check("jalr_wrap_pc", pc_o, 32'h4);
        step();
        step();
        check("jalr_wrap_after", pc_o, 32'hC);
        ex_valid_i  = 1'b1;
        ex_is_jal_i = 1'b1;
        ex_pc_i     = 32'hFFFF_FFFC;
        ex_imm_i    = 32'h10;
        #1;
        check("jal_link_wrap", link_o, 32'h0);
        check("jal_redirect", {31'b0, redirect_o}, 32'h1);
        idle();
        step();
        check("jal_cancelled_pc", pc_o, 32'h10);

        // Stall inside FLUSH freezes the counter; reset aborts FLUSH
        ex_valid_i  = 1'b1;
        ex_is_jal_i = 1'b1;
        ex_pc_i     = 32'h200;
        ex_imm_i    = 32'h40;
        step();
        idle();
        check("jal_pc", pc_o, 32'h240);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_flush_pc", pc_o, 32'h240);
            check("stall_flush_hi", {31'b0, flush_o}, 32'h1);
        end
        stall_i = 1'b0;
        step();
        check("unstall_pc", pc_o, 32'h244);
        check("unstall_flush", {31'b0, flush_o}, 32'h1);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("midrst_pc", pc_o, 32'h0);
        check("midrst_flush", {31'b0, flush_o}, 32'h0);
        drive_branch(3'b010, 32'h300, 32'h20, 1'b0, 1'b1);
        check("illegal_010", {31'b0, illegal_o}, 32'h1);
        check("illegal_no_redirect", {31'b0, redirect_o}, 32'h0);
        drive_branch(3'b011, 32'h300, 32'h20, 1'b1, 1'b1);
        check("illegal_011", {31'b0, illegal_o}, 32'h1);
        drive_branch(3'b001, 32'h300, 32'h20, 1'b0, 1'b0);
        check("bne_after_rst", {31'b0, redirect_o}, 32'h1);
        step();
        idle();
        check("bne_pc", pc_o, 32'h320);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage consumer of the branch comparator: turns br_less/br_equal plus decoded branch/jump info into a taken decision, target address and PC update.
- Owns the architectural fetch PC register, the pipeline squash window after a redirect, and the misaligned-target trap hand-off.
- Drives the comparator's unsigned-select from funct3.
- Static predict-not-taken: every taken branch or jump is a redirect.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-target trap
FLUSH_DEPTH, 2, cycles flush_o stays high after a redirect (1..7)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous reset, active low
stall_i  in  1  hold PC (fetch back-pressure)
ex_valid_i  in  1  EX stage holds a valid instruction
ex_is_branch_i  in  1  conditional branch
ex_is_jal_i  in  1  JAL
ex_is_jalr_i  in  1  JALR
ex_funct3_i  in  3  branch funct3
ex_pc_i  in  XLEN  PC of the EX instruction
ex_imm_i  in  XLEN  sign-extended immediate
ex_rs1_data_i  in  XLEN  rs1 operand (JALR base)
br_less_i  in  1  from comparator
br_equal_i  in  1  from comparator
trap_ack_i  in  1  trap handler accepted trap
br_unsigned_o  out  1  to comparator, unsigned compare select
pc_o  out  XLEN  fetch PC (registered)
link_o  out  XLEN  ex_pc_i + 4 (combinational, for rd write)
redirect_o  out  1  taken branch/jump this cycle (combinational)
flush_o  out  1  squash IF/ID (registered)
illegal_o  out  1  funct3 010/011 on valid branch (combinational)
trap_o  out  1  one-cycle misaligned-trap pulse (registered)
trap_addr_o  out  XLEN  offending target (registered)

Behaviour:
- Clock is clk_i; reset is rst_ni, synchronous and active-low.
- While rst_ni=0 at a rising edge, the following values load:
  - pc_o=RESET_PC
  - flush_o=0, trap_o=0, trap_addr_o=0
  - state=RUN, flush counter=0
- Reset overrides everything, including mid-FLUSH and mid-TRAP.
- br_unsigned_o = ex_funct3_i[1]. This is 1 for BLTU/BGEU, and is also driven when not valid.
- Taken decision from funct3:
  - 000: br_equal_i
  - 001: !br_equal_i
  - 100 and 110: br_less_i
  - 101 and 111: !br_less_i
  - 010 and 011: not taken, and illegal_o=ex_valid_i&ex_is_branch_i
- Target calculation, with modulo 2^XLEN wrap and no overflow flag:
  - Branch and JAL: ex_pc_i+ex_imm_i
  - JALR: (ex_rs1_data_i+ex_imm_i) with bit0 cleared
- event = ex_valid_i & state==RUN & (taken branch | jal | jalr). Only one of the is_* inputs is ever high; if more are high, JALR wins, then JAL, then branch.
- Misaligned = event & target[1]=1.
- redirect_o = event & !misaligned.
- States:
  - RUN
    - On redirect: pc_o<=target, flush counter<=FLUSH_DEPTH, flush_o<=1, go to FLUSH. Redirect overrides stall_i.
    - On misaligned: pc_o<=TRAP_VEC, trap_o<=1, trap_addr_o<=target, flush_o<=1, go to TRAP.
    - Otherwise: pc_o<=pc_o+4 if !stall_i, else hold.
  - FLUSH
    - ex_valid_i is ignored: no redirect, trap or illegal.
    - pc_o<=pc_o+4 when !stall_i.
    - Counter decrements only when !stall_i.
    - flush_o stays 1 until the counter reaches 0, then goes to RUN with flush_o<=0.
    - flush_o is therefore high for exactly FLUSH_DEPTH unstalled cycles.
  - TRAP
    - trap_o is high only on the first cycle, then 0.
    - pc_o holds TRAP_VEC, flush_o=1, ex_valid_i is ignored.
    - trap_ack_i=1 loads flush_o<=0 and goes to RUN. PC fetch resumes at TRAP_VEC the next cycle.
    - trap_ack_i in any other state is ignored.
- Latency:
  - Decision and redirect_o are in the same cycle as the EX inputs.
  - New pc_o is visible one cycle later.
- link_o = ex_pc_i+4 regardless of valid; wraps at 2^XLEN.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with stall_i=0 -> pc_o=0, flush_o=0. Release -> pc_o steps 4, 8, 12 on successive edges; stall_i=1 holds pc_o.
- BEQ taken, FLUSH_DEPTH=2: ex_pc_i=0x40, imm=0x20, funct3=000, br_equal_i=1 -> redirect_o=1 in the same cycle; pc_o=0x60 next cycle; flush_o high for exactly 2 cycles. A valid branch presented during those 2 cycles produces no redirect.
- Signed/unsigned select: funct3=110 -> br_unsigned_o=1; funct3=101 -> 0. BGE with br_less_i=1 -> not taken and pc_o+4; BLTU with br_less_i=1 -> taken.
- JALR: rs1=0x1003, imm=0 -> target 0x1002 (bit1 set) -> trap_o pulse, trap_addr_o=0x1002, pc_o=0x100. pc_o holds 0x100 until trap_ack_i, then 0x104.
- JALR aligned with wrap: rs1=0xFFFF_FFFC, imm=8 -> pc_o=0x0000_0004. JAL at ex_pc_i=0xFFFF_FFFC -> link_o=0.
- Stall during FLUSH plus mid-operation reset: redirect, then stall_i=1 for 3 cycles -> flush_o stays 1 and the counter does not move. Drop rst_ni in FLUSH -> pc_o=RESET_PC, flush_o=0, state RUN. funct3=010 valid -> illegal_o=1, no redirect.
